trigger_sequencer: RTL and testbench
====================================

TRIGGER_SEQUENCER -- requirements
Module: trigger_sequencer

Interface
REQ-001 SHALL have parameter NUM_TRIGGER_LINES, default 4, number of trigger inputs (1..32).
REQ-002 SHALL have parameter HOLDOFF_WIDTH, default 16, holdoff counter width.
REQ-003 SHALL have parameter POST_WIDTH, default 16, post-trigger counter width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port arm  input  1  synchronous arm request.
REQ-007 SHALL have port disarm  input  1  synchronous abort to DISARMED.
REQ-008 SHALL have port triggers  input  NUM_TRIGGER_LINES  raw trigger lines.
REQ-009 SHALL have port mask  input  NUM_TRIGGER_LINES  1 = line participates.
REQ-010 SHALL have port edge_mode  input  NUM_TRIGGER_LINES  1 = edge, 0 = level.
REQ-011 SHALL have port polarity  input  NUM_TRIGGER_LINES  1 = rising/high, 0 = falling/low.
REQ-012 SHALL have port combine_all  input  1  1 = AND of enabled lines, 0 = OR.
REQ-013 SHALL have port holdoff  input  HOLDOFF_WIDTH  cycles spent in HOLDOFF after arm.
REQ-014 SHALL have port post_count  input  POST_WIDTH  cycles spent in TRIGGERED.
REQ-015 SHALL have port state  output  3  current state encoding.
REQ-016 SHALL have port trig_pulse  output  1  one-cycle trigger strobe.
REQ-017 SHALL have port done  output  1  high while in DONE.
REQ-018 SHALL have port trigger_source  output  NUM_TRIGGER_LINES  qualified lines latched at trigger.

Function
REQ-019 SHALL register triggers every cycle into trig_q, and trig_q into trig_prev, regardless of state.
REQ-020 SHALL qualify each line as: level -> trig_q==polarity; edge rising -> trig_q & ~trig_prev; edge falling -> ~trig_q & trig_prev.
REQ-021 SHALL form hit as OR (combine_all=0) or AND (combine_all=1) over qualified lines with mask=1; mask all-zero -> hit never asserts.
REQ-022 SHALL implement states DISARMED=0, HOLDOFF=1, ARMED=2, TRIGGERED=3, DONE=4.
REQ-023 DISARMED or DONE + arm: holdoff sampled; holdoff=0 -> ARMED next cycle, else HOLDOFF for exactly holdoff cycles, then ARMED.
REQ-024 hit SHALL be ignored in DISARMED, HOLDOFF, TRIGGERED, DONE.
REQ-025 ARMED + hit: post_count sampled, trigger_source latches qualified&mask, trig_pulse high for the first cycle of the next state; post_count=0 -> DONE, else TRIGGERED for exactly post_count cycles, then DONE.
REQ-026 Latency: line change before edge k -> trig_q at k -> state change and trig_pulse at k+1.
REQ-027 DONE SHALL persist until arm or disarm; done = (state==DONE).
REQ-028 disarm SHALL force DISARMED next cycle from any state, priority over arm and hit; counters cleared, trigger_source retained.
REQ-029 arm in HOLDOFF, ARMED, TRIGGERED SHALL be ignored.
REQ-030 mask, edge_mode, polarity, combine_all SHALL be live (not sampled).

Reset
REQ-031 rst_n low SHALL asynchronously set state=DISARMED, trig_q=trig_prev=0, counters=0, trig_pulse=0, done=0, trigger_source=0.
REQ-032 Reset mid-operation SHALL abort without trig_pulse; first arm after release behaves as from power-up.

Structure
REQ-033 State encodings and state width SHALL live in shared package mso_trigger_pkg.
REQ-034 Per-line qualification plus combine (REQ-019..021) SHALL be sub-module trigger_qualifier, outputs hit and qualified vector.

Verification
REQ-035 OR, mask=4'b0100, edge rising, holdoff=3, post=5: arm, line2 rises -> HOLDOFF 3 cycles, trig_pulse 1 cycle at k+1, TRIGGERED 5 cycles, DONE, trigger_source=4'b0100.
REQ-036 AND, mask=4'b0011, level high: line0 high only -> no trigger; line1 also high -> trigger, trigger_source=4'b0011.
REQ-037 Line held high before arm, edge mode, holdoff=0 -> no trigger until a fresh rising edge.
REQ-038 Edge during HOLDOFF -> ignored; arm+disarm same cycle -> stays DISARMED.
REQ-039 disarm in TRIGGERED with post=10 at cycle 4 -> DISARMED next cycle, done never asserts.
REQ-040 rst_n low mid-HOLDOFF -> all outputs zero immediately; post_count=0 trigger -> DONE directly with one trig_pulse.

Source files
------------

// File: rtl/mso_trigger_pkg.sv
// mso_trigger_pkg: state encodings and widths shared by the trigger sequencer files
package mso_trigger_pkg;
    localparam int STATE_W = 3;
    typedef enum logic [STATE_W-1:0] {
        ST_DISARMED  = 3'd0,
        ST_HOLDOFF   = 3'd1,
        ST_ARMED     = 3'd2,
        ST_TRIGGERED = 3'd3,
        ST_DONE      = 3'd4
    } state_t;
endpackage

// File: rtl/trigger_qualifier.sv
// trigger_qualifier: registers the raw lines, qualifies each as level/edge and combines them
// Ports: clk, rst_n (async active-low); triggers/mask/edge_mode/polarity per line;
//        combine_all selects AND (1) or OR (0); hit and qualified are combinational from trig_q/trig_prev.
module trigger_qualifier #(
    parameter int NUM_TRIGGER_LINES = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_TRIGGER_LINES-1:0] triggers,
    input  logic [NUM_TRIGGER_LINES-1:0] mask,
    input  logic [NUM_TRIGGER_LINES-1:0] edge_mode,
    input  logic [NUM_TRIGGER_LINES-1:0] polarity,
    input  logic                         combine_all,
    output logic                         hit,
    output logic [NUM_TRIGGER_LINES-1:0] qualified
);
    logic [NUM_TRIGGER_LINES-1:0] trig_q, trig_prev_q, rise, fall, lvl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_q      <= '0;
            trig_prev_q <= '0;
        end else begin
            trig_q      <= triggers;
            trig_prev_q <= trig_q;
        end
    end

    assign rise      = trig_q & ~trig_prev_q;
    assign fall      = ~trig_q & trig_prev_q;
    assign lvl       = ~(trig_q ^ polarity);
    assign qualified = (edge_mode & ((polarity & rise) | (~polarity & fall))) | (~edge_mode & lvl);
    // Unmasked lines are forced true for AND and false for OR; an empty mask never hits.
    assign hit = (|mask) & (combine_all ? &(qualified | ~mask) : |(qualified & mask));
endmodule

// File: rtl/trigger_sequencer.sv
// trigger_sequencer: arm/holdoff/armed/triggered/done sequencer over qualified trigger lines
// Ports: clk, rst_n (async active-low); arm/disarm control; trigger line config (live);
//        holdoff and post_count sampled on entry; state, trig_pulse, done, trigger_source registered.
module trigger_sequencer
    import mso_trigger_pkg::*;
#(
    parameter int NUM_TRIGGER_LINES = 4,
    parameter int HOLDOFF_WIDTH     = 16,
    parameter int POST_WIDTH        = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         arm,
    input  logic                         disarm,
    input  logic [NUM_TRIGGER_LINES-1:0] triggers,
    input  logic [NUM_TRIGGER_LINES-1:0] mask,
    input  logic [NUM_TRIGGER_LINES-1:0] edge_mode,
    input  logic [NUM_TRIGGER_LINES-1:0] polarity,
    input  logic                         combine_all,
    input  logic [HOLDOFF_WIDTH-1:0]     holdoff,
    input  logic [POST_WIDTH-1:0]        post_count,
    output logic [STATE_W-1:0]           state,
    output logic                         trig_pulse,
    output logic                         done,
    output logic [NUM_TRIGGER_LINES-1:0] trigger_source
);
    logic                         hit;
    logic [NUM_TRIGGER_LINES-1:0] qualified;
    state_t                       state_q;
    logic [HOLDOFF_WIDTH-1:0]     hold_cnt_q;
    logic [POST_WIDTH-1:0]        post_cnt_q;
    logic                         trig_pulse_q, done_q;
    logic [NUM_TRIGGER_LINES-1:0] src_q;

    trigger_qualifier #(.NUM_TRIGGER_LINES(NUM_TRIGGER_LINES)) u_qual (
        .clk         (clk),
        .rst_n       (rst_n),
        .triggers    (triggers),
        .mask        (mask),
        .edge_mode   (edge_mode),
        .polarity    (polarity),
        .combine_all (combine_all),
        .hit         (hit),
        .qualified   (qualified)
    );

    // Counters are loaded with N-1 so that each timed state lasts exactly N cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_DISARMED;
            hold_cnt_q   <= '0;
            post_cnt_q   <= '0;
            trig_pulse_q <= 1'b0;
            done_q       <= 1'b0;
            src_q        <= '0;
        end else begin
            trig_pulse_q <= 1'b0;
            if (disarm) begin
                state_q    <= ST_DISARMED;
                hold_cnt_q <= '0;
                post_cnt_q <= '0;
                done_q     <= 1'b0;
            end else begin
                case (state_q)
                    ST_DISARMED, ST_DONE: begin
                        if (arm) begin
                            done_q <= 1'b0;
                            if (holdoff == '0) begin
                                state_q <= ST_ARMED;
                            end else begin
                                state_q    <= ST_HOLDOFF;
                                hold_cnt_q <= holdoff - 1'b1;
                            end
                        end
                    end
                    ST_HOLDOFF: begin
                        if (hold_cnt_q == '0) state_q <= ST_ARMED;
                        else hold_cnt_q <= hold_cnt_q - 1'b1;
                    end
                    ST_ARMED: begin
                        if (hit) begin
                            trig_pulse_q <= 1'b1;
                            src_q        <= qualified & mask;
                            if (post_count == '0) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q    <= ST_TRIGGERED;
                                post_cnt_q <= post_count - 1'b1;
                            end
                        end
                    end
                    ST_TRIGGERED: begin
                        if (post_cnt_q == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            post_cnt_q <= post_cnt_q - 1'b1;
                        end
                    end
                    default: state_q <= ST_DISARMED;
                endcase
            end
        end
    end

    assign state          = state_q;
    assign trig_pulse     = trig_pulse_q;
    assign done           = done_q;
    assign trigger_source = src_q;
endmodule

// File: tb/tb_trigger_sequencer.sv
// tb_trigger_sequencer: directed checks of the trigger sequencer with immediate assertions
module tb_trigger_sequencer;
    logic        clk = 1'b0;
    logic        rst_n, arm, disarm, combine_all;
    logic [3:0]  triggers, mask, edge_mode, polarity;
    logic [15:0] holdoff, post_count;
    logic [2:0]  state;
    logic        trig_pulse, done;
    logic [3:0]  trigger_source;
    int          n_cmp = 0;
    int          n_err = 0;

    trigger_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .arm            (arm),
        .disarm         (disarm),
        .triggers       (triggers),
        .mask           (mask),
        .edge_mode      (edge_mode),
        .polarity       (polarity),
        .combine_all    (combine_all),
        .holdoff        (holdoff),
        .post_count     (post_count),
        .state          (state),
        .trig_pulse     (trig_pulse),
        .done           (done),
        .trigger_source (trigger_source)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] st, input logic tp, input logic dn, input logic [3:0] src);
        chk({tag, ".state"}, {29'd0, state}, {29'd0, st});
        chk({tag, ".pulse"}, {31'd0, trig_pulse}, {31'd0, tp});
        chk({tag, ".done"}, {31'd0, done}, {31'd0, dn});
        chk({tag, ".src"}, {28'd0, trigger_source}, {28'd0, src});
    endtask

    initial begin
        rst_n = 1'b0; arm = 1'b0; disarm = 1'b0; combine_all = 1'b0;
        triggers = 4'b0000; mask = 4'b0100; edge_mode = 4'b1111; polarity = 4'b1111;
        holdoff = 16'd3; post_count = 16'd5;
        #2;
        chk_all("reset", 3'd0, 1'b0, 1'b0, 4'b0000);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk_all("idle", 3'd0, 1'b0, 1'b0, 4'b0000);

        // OR, rising edge on line 2, holdoff 3, post 5
        arm = 1'b1; tick(); arm = 1'b0;
        chk("s1.ho1", {29'd0, state}, 32'd1);
        tick(); chk("s1.ho2", {29'd0, state}, 32'd1);
        tick(); chk("s1.ho3", {29'd0, state}, 32'd1);
        tick(); chk("s1.armed", {29'd0, state}, 32'd2);
        triggers = 4'b0100;
        tick(); chk_all("s1.k", 3'd2, 1'b0, 1'b0, 4'b0000);
        tick(); chk_all("s1.k1", 3'd3, 1'b1, 1'b0, 4'b0100);
        for (int i = 0; i < 4; i++) begin
            tick(); chk_all("s1.trig", 3'd3, 1'b0, 1'b0, 4'b0100);
        end
        tick(); chk_all("s1.done", 3'd4, 1'b0, 1'b1, 4'b0100);
        tick(); tick(); chk_all("s1.hold", 3'd4, 1'b0, 1'b1, 4'b0100);

        // AND of lines 0,1 in level-high mode
        combine_all = 1'b1; mask = 4'b0011; edge_mode = 4'b0000; polarity = 4'b1111;
        holdoff = 16'd0; post_count = 16'd2; triggers = 4'b0001;
        arm = 1'b1; tick(); arm = 1'b0;
        chk_all("s2.armed", 3'd2, 1'b0, 1'b0, 4'b0100);
        for (int i = 0; i < 3; i++) begin
            tick(); chk("s2.only0", {29'd0, state}, 32'd2);
        end
        triggers = 4'b0011;
        tick(); chk("s2.k", {29'd0, state}, 32'd2);
        tick(); chk_all("s2.k1", 3'd3, 1'b1, 1'b0, 4'b0011);
        tick(); chk_all("s2.trig2", 3'd3, 1'b0, 1'b0, 4'b0011);
        tick(); chk_all("s2.done", 3'd4, 1'b0, 1'b1, 4'b0011);

        // disarm from DONE keeps trigger_source
        disarm = 1'b1; tick(); disarm = 1'b0;
        chk_all("dis", 3'd0, 1'b0, 1'b0, 4'b0011);

        // line 0 held high before arm, edge mode: needs a fresh rising edge; post 0 goes straight to DONE
        combine_all = 1'b0; mask = 4'b0001; edge_mode = 4'b1111; holdoff = 16'd0; post_count = 16'd0;
        arm = 1'b1; tick(); arm = 1'b0;
        chk("s3.armed", {29'd0, state}, 32'd2);
        for (int i = 0; i < 3; i++) begin
            tick(); chk("s3.held", {29'd0, state}, 32'd2);
        end
        triggers = 4'b0000;
        tick(); tick(); chk_all("s3.fall", 3'd2, 1'b0, 1'b0, 4'b0011);
        triggers = 4'b0001;
        tick(); chk("s3.k", {29'd0, state}, 32'd2);
        tick(); chk_all("s3.k1", 3'd4, 1'b1, 1'b1, 4'b0001);
        tick(); chk_all("s3.after", 3'd4, 1'b0, 1'b1, 4'b0001);

        // arm and disarm together stay DISARMED
        arm = 1'b1; disarm = 1'b1; tick(); arm = 1'b0; disarm = 1'b0;
        chk_all("s4.both", 3'd0, 1'b0, 1'b0, 4'b0001);
        tick(); chk("s4.stay", {29'd0, state}, 32'd0);

        // edge during HOLDOFF is ignored
        triggers = 4'b0000; holdoff = 16'd4; post_count = 16'd10;
        tick();
        arm = 1'b1; tick(); arm = 1'b0;
        chk("s4.ho", {29'd0, state}, 32'd1);
        triggers = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            tick(); chk_all("s4.hoedge", 3'd1, 1'b0, 1'b0, 4'b0001);
        end
        tick(); chk_all("s4.armed", 3'd2, 1'b0, 1'b0, 4'b0001);
        tick(); tick(); chk_all("s4.noedge", 3'd2, 1'b0, 1'b0, 4'b0001);

        // disarm during TRIGGERED (post 10) at its 4th cycle
        triggers = 4'b0000; tick(); tick();
        triggers = 4'b0001; tick();
        tick(); chk_all("s5.t1", 3'd3, 1'b1, 1'b0, 4'b0001);
        for (int i = 0; i < 3; i++) begin
            tick(); chk_all("s5.t", 3'd3, 1'b0, 1'b0, 4'b0001);
        end
        disarm = 1'b1; tick(); disarm = 1'b0;
        chk_all("s5.dis", 3'd0, 1'b0, 1'b0, 4'b0001);
        tick(); chk("s5.nodone", {31'd0, done}, 32'd0);

        // async reset mid-HOLDOFF
        holdoff = 16'd5;
        arm = 1'b1; tick(); arm = 1'b0;
        tick(); chk("s6.ho", {29'd0, state}, 32'd1);
        rst_n = 1'b0; #1;
        chk_all("s6.rst", 3'd0, 1'b0, 1'b0, 4'b0000);
        triggers = 4'b0000;
        tick(); rst_n = 1'b1;
        holdoff = 16'd0;
        arm = 1'b1; tick(); arm = 1'b0;
        chk_all("s6.rearm", 3'd2, 1'b0, 1'b0, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
